retire_ctrl: RTL and testbench
==============================

// Module: retire_ctrl
// PURPOSE
//  N-wide in-order retirement controller between the ROB head window and arch_maptable/freelist.
//  Generalises single-cycle retire with four additions:
//  - mispredicted branch in any slot (not only the head) plus all older entries retire in the same cycle;
//  - multi-cycle recovery hold;
//  - valid/ready store-commit handshake with the store queue;
//  - halt state and wrapping performance counters.
// PARAMETERS
//  N            `N                 retire width (head slots); slot N-1 oldest, 0 youngest
//  ARCH_COUNT   32                 architectural registers
//  PHYS_REGS    `PHYS_REG_SZ_R10K  physical registers; PRW = max(1,$clog2(PHYS_REGS))
//  RECOVER_LAT  2                  cycles (>=1) retire stalls after a mispredict, for map/freelist reseed
//  CNT_W        32                 width of each performance counter
// PORTS
//  clock            in   1                    system clock, all state on posedge
//  reset            in   1                    synchronous, active-high
//  head_entries     in   ROB_ENTRY[N-1:0]     ROB head window; uses complete, has_dest, dest_ar, Tnew, Told, branch,
//                                             pred_taken, branch_taken, pred_target, branch_target, rob_idx, is_store, halt
//  head_valids      in   N                    slot valid
//  st_commit_ready  in   1                    store queue accepts a commit this cycle
//  st_commit_valid  out  1                    store at scan point is complete and all older entries retire
//  st_commit_idx    out  ROB_IDX              rob_idx of that store
//  rob_retire_cnt   out  $clog2(N+1)          entries ROB pops this cycle (contiguous from slot N-1)
//  rob_mispredict   out  1                    flush everything younger than rob_mispred_idx
//  rob_mispred_idx  out  ROB_IDX              rob_idx of the mispredicted branch
//  BPRecoverEN      out  1                    map_table copies precise->spec
//  Arch_Retire_EN   out  N                    arch_maptable write enable per slot
//  Arch_Retire_AR   out  N x $clog2(ARCH_COUNT)  arch dest per slot
//  Arch_Tnew_in     out  N x PRW              new physical per slot
//  FL_RetireEN      out  N                    freelist return enable per slot
//  FL_RetireReg     out  N x PRW              Told returned per slot
//  recover_busy     out  1                    high while in RECOVER
//  halted           out  1                    high in HALTED
//  retired_cnt      out  CNT_W                instructions retired, wraps mod 2^CNT_W
//  mispred_cnt      out  CNT_W                mispredicts taken, wraps
// BEHAVIOUR
//  Reset: state=NORMAL, counters=0, recovery counter=0.
//   In any cycle with reset=1 all combinational outputs are forced to 0.
//  FSM states: NORMAL, RECOVER, HALTED.
//   Retire outputs are combinational from the head window and state (0 latency); state and counters update on posedge.
//  NORMAL scan, w=N-1 down to 0, stops at first hit of:
//   - invalid slot;
//   - incomplete entry;
//   - stop condition below.
//  Each retired slot: if has_dest && dest_ar!=0, assert Arch_Retire_EN/AR/Tnew and FL_RetireEN/Reg=Told.
//   Writes to x0 are fully suppressed.
//  mispred = branch && (pred_taken!=branch_taken || (branch_taken && pred_target!=branch_target)).
//   Mispredicted complete slot: it retires (incl. dest writes), scan stops.
//   Assert rob_mispredict, BPRecoverEN, rob_mispred_idx for that cycle only.
//   Next state RECOVER, counter loaded with RECOVER_LAT.
//  Store (complete): st_commit_valid=1, st_commit_idx=rob_idx.
//   Retires iff st_commit_ready; scan stops after it either way (max one store per cycle).
//  Halt (complete): retires, scan stops, next state HALTED.
//  Mispredicted branch is never also a store/halt. Store and halt checks apply only to entries reached by the scan.
//  rob_retire_cnt = number of slots retired this cycle; retired_cnt += rob_retire_cnt; mispred_cnt += 1 per mispredict.
//  RECOVER: no retire, st_commit_valid=0, recover_busy=1.
//   Counter decrements each cycle; when it reaches 1, next state NORMAL.
//   Head window contents ignored.
//  HALTED: sticky until reset; all retire/commit outputs 0, halted=1.
//  Reset asserted mid-RECOVER or in HALTED returns to NORMAL next cycle, with no partial outputs during the reset cycle.
//  Counters hold in RECOVER/HALTED.
// TESTING (N=2, RECOVER_LAT=2)
//  1. Both slots valid, complete, dest_ar 5/6, Told 40/41
//     -> Arch_Retire_EN=2'b11, FL_RetireReg={40,41}, rob_retire_cnt=2, retired_cnt 0->2.
//  2. Slot1 complete store, st_commit_ready=0 for 3 cycles then 1
//     -> st_commit_valid=1 for 4 cycles, rob_retire_cnt=0,0,0,1; slot0 never retires with it.
//  3. Slot1 complete ALU, slot0 branch pred_taken=0/taken=1, rob_idx=7
//     -> rob_retire_cnt=2, rob_mispredict=1, idx=7 for one cycle; recover_busy=1 for 2 cycles; mispred_cnt=1.
//  4. Slot1 incomplete, slot0 complete -> nothing retires, rob_retire_cnt=0.
//  5. Slot1 halt complete -> retires, halted=1 next cycle, stays with valid complete heads; reset clears it.
//  6. Reset asserted during RECOVER, then slot1 has_dest dest_ar=0
//     -> NORMAL after reset; Arch_Retire_EN=0, FL_RetireEN=0, rob_retire_cnt=1.

Source files
------------

// File: rtl/retire_ctrl_if.sv
// Shared types and the port bundle for the retirement controller.
//
// retire_pkg holds the ROB entry layout and the architectural/physical
// register sizing that every retire-side block has to agree on
// (ARCH_COUNT, PHYS_REGS and the derived AR_W / PRW).
//
// retire_ctrl_if groups everything except clock/reset:
//   head_entries, head_valids      ROB head window, slot N-1 oldest
//   st_commit_ready / _valid / _idx  store-commit handshake with the store queue
//   rob_retire_cnt, rob_mispredict, rob_mispred_idx   ROB pop / flush control
//   BPRecoverEN                    map table precise->spec copy
//   Arch_Retire_*                  arch map table writes per slot
//   FL_Retire*                     freelist returns per slot
//   recover_busy, halted           status
//   retired_cnt, mispred_cnt       wrapping performance counters
//   state_dbg                      raw controller state, for observation only
// Modport master is the retire controller; slave is the ROB/map/freelist side.
package retire_pkg;
  localparam int ARCH_COUNT = 32;
  localparam int PHYS_REGS  = 64;
  localparam int ROB_IDX_W  = 5;
  localparam int XLEN       = 32;
  localparam int AR_W       = (ARCH_COUNT > 1) ? $clog2(ARCH_COUNT) : 1;
  localparam int PRW        = (PHYS_REGS > 1) ? $clog2(PHYS_REGS) : 1;

  typedef struct packed {
    logic                 complete;
    logic                 has_dest;
    logic [AR_W-1:0]      dest_ar;
    logic [PRW-1:0]       Tnew;
    logic [PRW-1:0]       Told;
    logic                 branch;
    logic                 pred_taken;
    logic                 branch_taken;
    logic [XLEN-1:0]      pred_target;
    logic [XLEN-1:0]      branch_target;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 is_store;
    logic                 halt;
  } rob_entry_t;
endpackage

interface retire_ctrl_if #(
  parameter int N     = 2,
  parameter int CNT_W = 32
);
  import retire_pkg::*;
  localparam int RCW = $clog2(N + 1);

  rob_entry_t [N-1:0]           head_entries;
  logic [N-1:0]                 head_valids;

  // Store commit handshake: st_commit_valid is raised whenever the scan
  // reaches a complete store; the store (and the retire of its slot) happens
  // in a cycle where st_commit_valid && st_commit_ready. valid does not wait
  // for ready, and idx is stable while valid is held.
  logic                         st_commit_ready;
  logic                         st_commit_valid;
  logic [ROB_IDX_W-1:0]         st_commit_idx;

  logic [RCW-1:0]               rob_retire_cnt;
  logic                         rob_mispredict;
  logic [ROB_IDX_W-1:0]         rob_mispred_idx;
  logic                         BPRecoverEN;
  logic [N-1:0]                 Arch_Retire_EN;
  logic [N-1:0][AR_W-1:0]       Arch_Retire_AR;
  logic [N-1:0][PRW-1:0]        Arch_Tnew_in;
  logic [N-1:0]                 FL_RetireEN;
  logic [N-1:0][PRW-1:0]        FL_RetireReg;
  logic                         recover_busy;
  logic                         halted;
  logic [CNT_W-1:0]             retired_cnt;
  logic [CNT_W-1:0]             mispred_cnt;
  logic [1:0]                   state_dbg;

  modport master (
    input  head_entries, head_valids, st_commit_ready,
    output st_commit_valid, st_commit_idx, rob_retire_cnt, rob_mispredict,
           rob_mispred_idx, BPRecoverEN, Arch_Retire_EN, Arch_Retire_AR,
           Arch_Tnew_in, FL_RetireEN, FL_RetireReg, recover_busy, halted,
           retired_cnt, mispred_cnt, state_dbg
  );

  modport slave (
    output head_entries, head_valids, st_commit_ready,
    input  st_commit_valid, st_commit_idx, rob_retire_cnt, rob_mispredict,
           rob_mispred_idx, BPRecoverEN, Arch_Retire_EN, Arch_Retire_AR,
           Arch_Tnew_in, FL_RetireEN, FL_RetireReg, recover_busy, halted,
           retired_cnt, mispred_cnt, state_dbg
  );
endinterface

// File: rtl/retire_ctrl.sv
// N-wide in-order retirement controller between the ROB head window and the
// arch map table / freelist.
//
// Ports:
//   clock  system clock, all state on posedge
//   reset  synchronous, active-high; forces every combinational output to 0
//   bus    retire_ctrl_if.master (head window in, retire/commit/status out)
//
// Retire decisions are combinational from the head window and the current
// state. The scan walks slot N-1 (oldest) toward slot 0 and stops at an
// invalid or incomplete slot, a store (one per cycle, retires only when
// accepted), a mispredicted branch (retires, then RECOVER_LAT stall cycles)
// or a halt (retires, then HALTED until reset). Architectural register and
// physical register sizing come from retire_pkg.
module retire_ctrl
  import retire_pkg::*;
#(
  parameter int N           = 2,
  parameter int RECOVER_LAT = 2,
  parameter int CNT_W       = 32
) (
  input  logic          clock,
  input  logic          reset,
  retire_ctrl_if.master bus
);

  localparam int RCW = $clog2(N + 1);
  localparam int RLW = (RECOVER_LAT > 1) ? $clog2(RECOVER_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_NORMAL  = 2'd0,
    S_RECOVER = 2'd1,
    S_HALTED  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [RLW-1:0]       rec_q, rec_d;
  logic [CNT_W-1:0]     retired_q, mispred_q;

  logic [N-1:0]         retire_mask;
  logic                 mispred_hit;
  logic [ROB_IDX_W-1:0] mispred_idx;
  logic                 halt_hit;
  logic                 st_valid;
  logic [ROB_IDX_W-1:0] st_idx;
  logic                 stop;

  logic [RCW-1:0]       retire_cnt;
  logic [N-1:0]         arch_en;
  logic [N-1:0][AR_W-1:0] arch_ar;
  logic [N-1:0][PRW-1:0]  arch_tnew;
  logic [N-1:0]         fl_en;
  logic [N-1:0][PRW-1:0]  fl_reg;

  function automatic logic is_mispred(input rob_entry_t e);
    return e.branch && ((e.pred_taken != e.branch_taken) ||
                        (e.branch_taken && (e.pred_target != e.branch_target)));
  endfunction

  // Head window scan: decides which slots retire and which event ends the scan.
  always_comb begin
    retire_mask = '0;
    mispred_hit = 1'b0;
    mispred_idx = '0;
    halt_hit    = 1'b0;
    st_valid    = 1'b0;
    st_idx      = '0;
    stop        = 1'b0;
    if (!reset && state_q == S_NORMAL) begin
      for (int w = N - 1; w >= 0; w--) begin
        if (!stop) begin
          if (!bus.head_valids[w] || !bus.head_entries[w].complete) begin
            stop = 1'b1;
          end else if (bus.head_entries[w].is_store) begin
            // The store is offered even when it cannot retire; younger
            // slots must wait for it either way.
            st_valid       = 1'b1;
            st_idx         = bus.head_entries[w].rob_idx;
            retire_mask[w] = bus.st_commit_ready;
            stop           = 1'b1;
          end else begin
            retire_mask[w] = 1'b1;
            if (is_mispred(bus.head_entries[w])) begin
              mispred_hit = 1'b1;
              mispred_idx = bus.head_entries[w].rob_idx;
              stop        = 1'b1;
            end else if (bus.head_entries[w].halt) begin
              halt_hit = 1'b1;
              stop     = 1'b1;
            end
          end
        end
      end
    end
  end

  // Per-slot map table / freelist updates; x0 destinations are dropped.
  always_comb begin
    retire_cnt = '0;
    arch_en    = '0;
    arch_ar    = '0;
    arch_tnew  = '0;
    fl_en      = '0;
    fl_reg     = '0;
    for (int w = 0; w < N; w++) begin
      if (retire_mask[w]) begin
        retire_cnt = retire_cnt + RCW'(1);
        if (bus.head_entries[w].has_dest && bus.head_entries[w].dest_ar != '0) begin
          arch_en[w]   = 1'b1;
          arch_ar[w]   = bus.head_entries[w].dest_ar;
          arch_tnew[w] = bus.head_entries[w].Tnew;
          fl_en[w]     = 1'b1;
          fl_reg[w]    = bus.head_entries[w].Told;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    case (state_q)
      S_NORMAL: begin
        if (mispred_hit) begin
          state_d = S_RECOVER;
          rec_d   = RLW'(RECOVER_LAT);
        end else if (halt_hit) begin
          state_d = S_HALTED;
        end
      end
      S_RECOVER: begin
        // The last stall cycle is the one entered with the counter at 1.
        if (rec_q <= RLW'(1)) begin
          state_d = S_NORMAL;
          rec_d   = '0;
        end else begin
          rec_d = rec_q - RLW'(1);
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_NORMAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_NORMAL;
      rec_q     <= '0;
      retired_q <= '0;
      mispred_q <= '0;
    end else begin
      state_q   <= state_d;
      rec_q     <= rec_d;
      retired_q <= retired_q + CNT_W'(retire_cnt);
      if (mispred_hit) mispred_q <= mispred_q + CNT_W'(1);
    end
  end

  assign bus.st_commit_valid = st_valid;
  assign bus.st_commit_idx   = st_idx;
  assign bus.rob_retire_cnt  = retire_cnt;
  assign bus.rob_mispredict  = mispred_hit;
  assign bus.rob_mispred_idx = mispred_idx;
  assign bus.BPRecoverEN     = mispred_hit;
  assign bus.Arch_Retire_EN  = arch_en;
  assign bus.Arch_Retire_AR  = arch_ar;
  assign bus.Arch_Tnew_in    = arch_tnew;
  assign bus.FL_RetireEN     = fl_en;
  assign bus.FL_RetireReg    = fl_reg;
  assign bus.recover_busy    = !reset && (state_q == S_RECOVER);
  assign bus.halted          = !reset && (state_q == S_HALTED);
  assign bus.retired_cnt     = retired_q;
  assign bus.mispred_cnt     = mispred_q;
  assign bus.state_dbg       = state_q;

endmodule

// File: tb/tb_retire_ctrl.sv
// Testbench for retire_ctrl (N=2, RECOVER_LAT=2): directed scenarios followed
// by randomized head windows. A reference model derives the expected outputs
// of every cycle from the retirement rules and pushes them into exp_q; a
// negedge monitor pops and compares against the DUT.
module tb_retire_ctrl;
  import retire_pkg::*;

  localparam int N     = 2;
  localparam int RL    = 2;
  localparam int CNT_W = 32;
  localparam int RCW   = $clog2(N + 1);

  typedef struct packed {
    logic [RCW-1:0]         retire_cnt;
    logic                   mispredict;
    logic [ROB_IDX_W-1:0]   mispred_idx;
    logic                   bprecover;
    logic [N-1:0]           arch_en;
    logic [N-1:0][AR_W-1:0] arch_ar;
    logic [N-1:0][PRW-1:0]  tnew;
    logic [N-1:0]           fl_en;
    logic [N-1:0][PRW-1:0]  fl_reg;
    logic                   st_valid;
    logic [ROB_IDX_W-1:0]   st_idx;
    logic                   busy;
    logic                   halted;
    logic [CNT_W-1:0]       rcnt;
    logic [CNT_W-1:0]       mcnt;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  retire_ctrl_if #(.N(N), .CNT_W(CNT_W)) bus ();

  rob_entry_t [N-1:0] ent;
  logic [N-1:0]       vld;
  logic               ready;

  assign bus.head_entries    = ent;
  assign bus.head_valids     = vld;
  assign bus.st_commit_ready = ready;

  retire_ctrl #(.N(N), .RECOVER_LAT(RL), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  // ---------------- reference model state ----------------
  exp_t             exp_q[$];
  int               tests_run = 0;
  int               tests_failed = 0;
  logic [CNT_W-1:0] m_retired = '0;
  logic [CNT_W-1:0] m_mispred = '0;
  int               m_recover_left = 0;
  bit               m_halted = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Predicts the outputs for the inputs currently applied, queues them,
  // then advances the model across the clock edge.
  task automatic step();
    exp_t e;
    bit   halt_next;
    e = '0;
    halt_next = 1'b0;
    e.rcnt = m_retired;
    e.mcnt = m_mispred;
    if (!reset) begin
      if (m_halted) begin
        e.halted = 1'b1;
      end else if (m_recover_left > 0) begin
        e.busy = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          int         w;
          rob_entry_t x;
          bit         take;
          w = N - 1 - k;
          x = ent[w];
          if (!vld[w] || !x.complete) break;
          take = 1'b1;
          if (x.is_store) begin
            e.st_valid = 1'b1;
            e.st_idx   = x.rob_idx;
            take       = ready;
          end
          if (take) begin
            e.retire_cnt = e.retire_cnt + 1'b1;
            if (x.has_dest && x.dest_ar != 0) begin
              e.arch_en[w] = 1'b1;
              e.arch_ar[w] = x.dest_ar;
              e.tnew[w]    = x.Tnew;
              e.fl_en[w]   = 1'b1;
              e.fl_reg[w]  = x.Told;
            end
          end
          if (x.is_store) break;
          if (x.branch && (x.pred_taken != x.branch_taken ||
                           (x.branch_taken && x.pred_target != x.branch_target))) begin
            e.mispredict  = 1'b1;
            e.bprecover   = 1'b1;
            e.mispred_idx = x.rob_idx;
            break;
          end
          if (x.halt) begin
            halt_next = 1'b1;
            break;
          end
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clock);
    if (reset) begin
      m_retired      = '0;
      m_mispred      = '0;
      m_recover_left = 0;
      m_halted       = 1'b0;
    end else begin
      m_retired = m_retired + CNT_W'(e.retire_cnt);
      if (e.mispredict) begin
        m_mispred      = m_mispred + 1'b1;
        m_recover_left = RL;
      end else if (m_recover_left > 0) begin
        m_recover_left--;
      end
      if (halt_next) m_halted = 1'b1;
    end
    #1;
  endtask

  function automatic rob_entry_t alu(input int ar, input int tn, input int to, input int idx);
    rob_entry_t x;
    x = '0;
    x.complete = 1'b1;
    x.has_dest = 1'b1;
    x.dest_ar  = AR_W'(ar);
    x.Tnew     = PRW'(tn);
    x.Told     = PRW'(to);
    x.rob_idx  = ROB_IDX_W'(idx);
    return x;
  endfunction

  function automatic rob_entry_t rand_entry();
    rob_entry_t x;
    int         kind;
    x = '0;
    x.complete = ($urandom_range(0, 3) != 0);
    x.has_dest = 1'($urandom_range(0, 1));
    x.dest_ar  = ($urandom_range(0, 4) == 0) ? '0 : AR_W'($urandom_range(1, ARCH_COUNT - 1));
    x.Tnew     = PRW'($urandom);
    x.Told     = PRW'($urandom);
    x.rob_idx  = ROB_IDX_W'($urandom);
    kind = $urandom_range(0, 19);
    if (kind < 3) begin
      x.is_store = 1'b1;
    end else if (kind == 3) begin
      x.halt = 1'b1;
    end else if (kind < 10) begin
      x.branch        = 1'b1;
      x.pred_taken    = 1'($urandom_range(0, 1));
      x.branch_taken  = 1'($urandom_range(0, 1));
      x.pred_target   = XLEN'($urandom);
      x.branch_target = ($urandom_range(0, 1) != 0) ? x.pred_target : XLEN'($urandom);
    end
    return x;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("rob_retire_cnt", 64'(bus.rob_retire_cnt), 64'(e.retire_cnt));
      check("rob_mispredict", 64'(bus.rob_mispredict), 64'(e.mispredict));
      check("BPRecoverEN", 64'(bus.BPRecoverEN), 64'(e.bprecover));
      if (e.mispredict) check("rob_mispred_idx", 64'(bus.rob_mispred_idx), 64'(e.mispred_idx));
      check("Arch_Retire_EN", 64'(bus.Arch_Retire_EN), 64'(e.arch_en));
      check("FL_RetireEN", 64'(bus.FL_RetireEN), 64'(e.fl_en));
      for (int w = 0; w < N; w++) begin
        if (e.arch_en[w]) begin
          check("Arch_Retire_AR", 64'(bus.Arch_Retire_AR[w]), 64'(e.arch_ar[w]));
          check("Arch_Tnew_in", 64'(bus.Arch_Tnew_in[w]), 64'(e.tnew[w]));
        end
        if (e.fl_en[w]) check("FL_RetireReg", 64'(bus.FL_RetireReg[w]), 64'(e.fl_reg[w]));
      end
      check("st_commit_valid", 64'(bus.st_commit_valid), 64'(e.st_valid));
      if (e.st_valid) check("st_commit_idx", 64'(bus.st_commit_idx), 64'(e.st_idx));
      check("recover_busy", 64'(bus.recover_busy), 64'(e.busy));
      check("halted", 64'(bus.halted), 64'(e.halted));
      check("retired_cnt", 64'(bus.retired_cnt), 64'(e.rcnt));
      check("mispred_cnt", 64'(bus.mispred_cnt), 64'(e.mcnt));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    ent   = '0;
    vld   = '0;
    ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    step();              // reset cycle: outputs forced to 0
    reset = 1'b0;

    // Two ALU ops retire together.
    ent[1] = alu(5, 10, 40, 1);
    ent[0] = alu(6, 11, 41, 2);
    vld    = 2'b11;
    step();

    // Store at the oldest slot held off for three cycles.
    ent[1] = alu(0, 0, 0, 3);
    ent[1].has_dest = 1'b0;
    ent[1].is_store = 1'b1;
    ent[0] = alu(7, 12, 42, 4);
    ready  = 1'b0;
    repeat (3) step();
    ready = 1'b1;
    step();
    ready = 1'b0;

    // Mispredict in the younger slot, then the recovery stall.
    ent[1] = alu(8, 13, 43, 6);
    ent[0] = '0;
    ent[0].complete     = 1'b1;
    ent[0].branch       = 1'b1;
    ent[0].branch_taken = 1'b1;
    ent[0].rob_idx      = 5'd7;
    step();
    ent[1] = alu(9, 14, 44, 8);
    ent[0] = alu(10, 15, 45, 9);
    repeat (3) step();

    // Incomplete oldest blocks a complete younger slot.
    ent[1] = alu(11, 16, 46, 10);
    ent[1].complete = 1'b0;
    step();

    // Halt, stays halted, reset clears it.
    ent[1] = alu(0, 0, 0, 11);
    ent[1].halt = 1'b1;
    step();
    ent[1] = alu(12, 17, 47, 12);
    ent[0] = alu(13, 18, 48, 13);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Reset during recovery, then a write to x0.
    ent[1] = alu(14, 19, 49, 14);
    ent[1].branch       = 1'b1;
    ent[1].pred_taken   = 1'b1;
    ent[1].branch_taken = 1'b1;
    ent[1].pred_target  = 32'h100;
    ent[1].branch_target = 32'h200;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ent[1] = alu(0, 20, 50, 15);
    vld    = 2'b10;
    step();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      ent[1] = rand_entry();
      ent[0] = rand_entry();
      vld    = 2'($urandom_range(0, 3));
      ready  = 1'($urandom_range(0, 1));
      reset  = (m_halted && $urandom_range(0, 3) == 0) || ($urandom_range(0, 79) == 0);
      step();
    end
    reset = 1'b0;
    vld   = '0;
    step();

    @(negedge clock);
    #1;
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
